// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population counter.
// Loads a DATA_W-bit word on start, then counts ones (mode=0) or zeros
// (mode=1) STEP bits per clock and reports the result with a one-cycle done.
// Optional feature macro: POPCOUNT_EARLY_EXIT_EN. When it is defined, the
// count finishes as soon as the remaining shift register is all zero.
//
// Handshake: start is a request sampled only while busy=0. An accepted start
// raises busy on the same edge. done pulses for one cycle with count valid.
// busy drops one cycle after that pulse. A start seen while busy=1 is
// dropped, and it is not queued.
module popcount_seq #(
  parameter  int DATA_W = 8,
  parameter  int STEP   = 1,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [1:0]        dbg_state
);

  localparam int NSTEP = DATA_W / STEP;
  localparam int K_W   = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_sr;
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [K_W-1:0]     r_k;
  logic [CNT_W-1:0]   w_chunk_pop;
  logic [CNT_W-1:0]   w_acc_sum;
  logic               w_last;
  logic               w_early;

  // Ones in the low STEP bits of the shift register (the current chunk).
  always_comb begin
    w_chunk_pop = '0;
    for (int i = 0; i < STEP; i++) begin
      w_chunk_pop = w_chunk_pop + CNT_W'(r_sr[i]);
    end
  end

  assign w_acc_sum = r_acc + w_chunk_pop;
  assign w_last    = (r_k == K_W'(NSTEP - 1));

`ifdef POPCOUNT_EARLY_EXIT_EN
  // Nothing left to count once every remaining bit has been shifted out.
  assign w_early = (r_sr == '0);
`else
  assign w_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. DONE always returns to IDLE so that done is one cycle wide.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_COUNT;
      ST_COUNT: if (w_early || w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load on an accepted start, accumulate and shift while counting.
  // The result register is written only when the operation finishes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_sr    <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sr  <= mode ? ~din : din;
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        ST_COUNT: begin
          if (w_early) begin
            r_count <= r_acc;
          end else begin
            r_acc <= w_acc_sum;
            r_sr  <= r_sr >> STEP;
            r_k   <= r_k + K_W'(1);
            if (w_last) begin
              r_count <= w_acc_sum;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule
